// File: rtl/count_sched_pkg.sv
// Shared types and constants for the count operation scheduler.
package count_sched_pkg;

  // Scheduler sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  // Direction encoding carried on req_dir
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/count_op_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request bit,
// searching upward from rr_ptr and wrapping past the top index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic               grant_valid,
  output logic [IDW-1:0]     grant
);

  logic [IDW:0] pos;

  // Scan offsets from farthest to nearest so the nearest set bit wins last
  always_comb begin
    grant_valid = 1'b0;
    grant       = '0;
    pos         = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (pos >= (IDW+1)'(NUM_REQ)) begin
        pos = pos - (IDW+1)'(NUM_REQ);
      end else begin
        pos = pos;
      end
      if (req[pos[IDW-1:0]]) begin
        grant_valid = 1'b1;
        grant       = pos[IDW-1:0];
      end else begin
        grant_valid = grant_valid;
      end
    end
  end

endmodule

// File: rtl/count_op_scheduler.sv
// Shares one modulo-2^WIDTH up/down step counter among NUM_REQ requesters.
// One operation runs at a time; the counter moves one step per RUN cycle.
module count_op_scheduler
  import count_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int LEN_W   = 4,
  localparam int IDW    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ-1:0]       req_dir,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic                     clear,
  output logic [WIDTH-1:0]         cnt_value,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic                     done_valid,
  output logic [IDW-1:0]           done_id
);

  sched_state_t     state;
  logic [LEN_W-1:0] remaining;
  logic             dir;
  logic [IDW-1:0]   rr_ptr;
  logic             grant_valid;
  logic [IDW-1:0]   grant;
  logic [LEN_W-1:0] sel_len;
  logic             sel_dir;
  logic [IDW-1:0]   next_ptr;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req         (req_valid),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  // Operands of the granted requester and the rotated pointer past it
  always_comb begin
    sel_len = req_len[grant*LEN_W +: LEN_W];
    sel_dir = req_dir[grant];
    if (grant == IDW'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant + IDW'(1);
    end
  end

  // Accept pulse only in IDLE and never while reset holds the block
  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && grant_valid && !reset) begin
      req_ready[grant] = 1'b1;
    end else begin
      req_ready = '0;
    end
  end

  // Shared counter: clear wins over a step; it only moves in RUN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_value <= '0;
    end else if (clear) begin
      cnt_value <= '0;
    end else if (state == RUN) begin
      case (dir)
        DIR_UP:   cnt_value <= cnt_value + WIDTH'(1);
        DIR_DOWN: cnt_value <= cnt_value - WIDTH'(1);
        default:  cnt_value <= cnt_value;
      endcase
    end else begin
      cnt_value <= cnt_value;
    end
  end

  // Sequencer: accept/latch, step accounting, completion pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      remaining  <= '0;
      dir        <= 1'b0;
      rr_ptr     <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      done_valid <= 1'b0;
      done_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_valid <= 1'b0;
          if (grant_valid) begin
            grant_id  <= grant;
            rr_ptr    <= next_ptr;
            dir       <= sel_dir;
            remaining <= sel_len;
            busy      <= 1'b1;
            if (sel_len != LEN_W'(0)) begin
              state <= RUN;
            end else begin
              // Zero-length op goes straight to completion
              state      <= DONE;
              done_valid <= 1'b1;
              done_id    <= grant;
            end
          end else begin
            busy <= 1'b0;
          end
        end
        RUN: begin
          // A cleared cycle does not count as a step
          if (!clear) begin
            remaining <= remaining - LEN_W'(1);
            if (remaining == LEN_W'(1)) begin
              state      <= DONE;
              done_valid <= 1'b1;
              done_id    <= grant_id;
            end else begin
              state <= RUN;
            end
          end else begin
            remaining <= remaining;
          end
        end
        DONE: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          done_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_op_scheduler.sv
// Directed bench for count_op_scheduler with hand-computed expectations.
module tb_count_op_scheduler;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int LEN_W   = 4;
  localparam int IDW     = 2;

  logic                     clk;
  logic                     reset;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_dir;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     clear;
  logic [WIDTH-1:0]         cnt_value;
  logic                     busy;
  logic [IDW-1:0]           grant_id;
  logic                     done_valid;
  logic [IDW-1:0]           done_id;

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  count_op_scheduler #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_dir    (req_dir),
    .req_len    (req_len),
    .req_ready  (req_ready),
    .clear      (clear),
    .cnt_value  (cnt_value),
    .busy       (busy),
    .grant_id   (grant_id),
    .done_valid (done_valid),
    .done_id    (done_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic set_req(input int id, input logic v, input logic d, input logic [LEN_W-1:0] len);
    req_valid[id] = v;
    req_dir[id]   = d;
    req_len[id*LEN_W +: LEN_W] = len;
  endtask

  task automatic test_reset();
    reset = 1'b1; clear = 1'b0;
    req_valid = '0; req_dir = '0; req_len = '0;
    #2;
    tick(); tick();
    n_checks++; if (cnt_value !== 4'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", cnt_value); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL reset_done_valid: got %0b expected 0", done_valid); end
    n_checks++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL reset_done_id: got %0d expected 0", done_id); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_up();
    set_req(0, 1'b1, 1'b1, 4'd3);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL up_ready: got %b expected 0001", req_ready); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_busy_accept: got %0b expected 0", busy); end
    tick();
    set_req(0, 1'b0, 1'b1, 4'd0);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL up_ready_run: got %b expected 0000", req_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy_t1: got %0b expected 1", busy); end
    n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL up_grant_id: got %0d expected 0", grant_id); end
    n_checks++; if (cnt_value !== 4'd0) begin n_fail++; $display("FAIL up_cnt_t1: got %0d expected 0", cnt_value); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_checks++; if (cnt_value !== 4'(k)) begin n_fail++; $display("FAIL up_cnt_step%0d: got %0d expected %0d", k, cnt_value, k); end
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL up_busy_step%0d: got %0b expected 1", k, busy); end
      n_checks++; if (done_valid !== (k == 3)) begin n_fail++; $display("FAIL up_done_step%0d: got %0b expected %0b", k, done_valid, (k == 3)); end
    end
    n_checks++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL up_done_id: got %0d expected 0", done_id); end
    tick();
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL up_done_after: got %0b expected 0", done_valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL up_busy_after: got %0b expected 0", busy); end
  endtask

  task automatic test_down_wrap();
    logic [WIDTH-1:0] exp_cnt [3];
    exp_cnt[0] = 4'd0; exp_cnt[1] = 4'd15; exp_cnt[2] = 4'd14;
    // bring counter from 3 down to 1
    set_req(2, 1'b1, 1'b0, 4'd2);
    tick();
    set_req(2, 1'b0, 1'b0, 4'd0);
    tick(); tick(); tick(); tick();
    n_checks++; if (cnt_value !== 4'd1) begin n_fail++; $display("FAIL down_setup_cnt: got %0d expected 1", cnt_value); end
    set_req(2, 1'b1, 1'b0, 4'd3);
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL down_ready: got %b expected 0100", req_ready); end
    tick();
    set_req(2, 1'b0, 1'b0, 4'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++; if (cnt_value !== exp_cnt[k]) begin n_fail++; $display("FAIL down_cnt%0d: got %0d expected %0d", k, cnt_value, exp_cnt[k]); end
    end
    n_checks++; if (done_valid !== 1'b1) begin n_fail++; $display("FAIL down_done: got %0b expected 1", done_valid); end
    n_checks++; if (done_id !== 2'd2) begin n_fail++; $display("FAIL down_done_id: got %0d expected 2", done_id); end
    tick();
  endtask

  task automatic test_fairness();
    int last_done;
    int exp_id;
    logic [NUM_REQ-1:0] exp_rdy;
    last_done = 0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int r = 0; r < NUM_REQ; r++) set_req(r, 1'b1, 1'b1, 4'd1);
    for (int g = 0; g < 5; g++) begin
      exp_id  = g % NUM_REQ;
      exp_rdy = 4'b0001 << exp_id;
      #1;
      n_checks++; if (req_ready !== exp_rdy) begin n_fail++; $display("FAIL fair_ready%0d: got %b expected %b", g, req_ready, exp_rdy); end
      tick();
      n_checks++; if (grant_id !== 2'(exp_id)) begin n_fail++; $display("FAIL fair_grant%0d: got %0d expected %0d", g, grant_id, exp_id); end
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL fair_ready_run%0d: got %b expected 0000", g, req_ready); end
      tick();
      n_checks++; if (done_valid !== 1'b1 || done_id !== 2'(exp_id)) begin n_fail++; $display("FAIL fair_done%0d: got valid %0b id %0d expected valid 1 id %0d", g, done_valid, done_id, exp_id); end
      if (g > 0) begin
        n_checks++; if (cycle - last_done !== 3) begin n_fail++; $display("FAIL fair_spacing%0d: got %0d expected 3", g, cycle - last_done); end
      end
      last_done = cycle;
      tick();
    end
    req_valid = '0;
    #1;
    n_checks++; if (cnt_value !== 4'd5) begin n_fail++; $display("FAIL fair_cnt: got %0d expected 5", cnt_value); end
    tick();
  endtask

  task automatic test_zero_len();
    set_req(1, 1'b1, 1'b1, 4'd0);
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL zero_ready: got %b expected 0010", req_ready); end
    tick();
    set_req(1, 1'b0, 1'b1, 4'd0);
    n_checks++; if (done_valid !== 1'b1 || done_id !== 2'd1) begin n_fail++; $display("FAIL zero_done: got valid %0b id %0d expected valid 1 id 1", done_valid, done_id); end
    n_checks++; if (cnt_value !== 4'd5) begin n_fail++; $display("FAIL zero_cnt: got %0d expected 5", cnt_value); end
    tick();
    n_checks++; if (done_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got valid %0b busy %0b expected 0 0", done_valid, busy); end
    n_checks++; if (cnt_value !== 4'd5) begin n_fail++; $display("FAIL zero_cnt_after: got %0d expected 5", cnt_value); end
  endtask

  task automatic test_clear_mid_run();
    logic [WIDTH-1:0] exp_cnt [6];
    logic             exp_dv  [6];
    exp_cnt[0] = 4'd5; exp_cnt[1] = 4'd6; exp_cnt[2] = 4'd0;
    exp_cnt[3] = 4'd1; exp_cnt[4] = 4'd2; exp_cnt[5] = 4'd3;
    for (int k = 0; k < 6; k++) exp_dv[k] = (k == 5);
    set_req(0, 1'b1, 1'b1, 4'd4);
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL clr_ready: got %b expected 0001", req_ready); end
    tick();
    set_req(0, 1'b0, 1'b1, 4'd0);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      clear = (k == 1);
      n_checks++; if (cnt_value !== exp_cnt[k] || done_valid !== exp_dv[k]) begin n_fail++; $display("FAIL clr_cycle%0d: got cnt %0d done %0b expected cnt %0d done %0b", k, cnt_value, done_valid, exp_cnt[k], exp_dv[k]); end
    end
    n_checks++; if (done_id !== 2'd0) begin n_fail++; $display("FAIL clr_done_id: got %0d expected 0", done_id); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    set_req(0, 1'b1, 1'b1, 4'd8);
    tick();
    set_req(0, 1'b0, 1'b1, 4'd0);
    tick(); tick();
    set_req(1, 1'b1, 1'b1, 4'd2);
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready_busy: got %b expected 0000", req_ready); end
    #1;
    reset = 1'b1;
    #1;
    n_checks++; if (cnt_value !== 4'd0 || busy !== 1'b0 || done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async: got cnt %0d busy %0b done %0b expected 0 0 0", cnt_value, busy, done_valid); end
    n_checks++; if (grant_id !== 2'd0 || done_id !== 2'd0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_async_ids: got grant %0d done_id %0d ready %b expected 0 0 0000", grant_id, done_id, req_ready); end
    tick();
    n_checks++; if (done_valid !== 1'b0) begin n_fail++; $display("FAIL rst_no_done: got %0b expected 0", done_valid); end
    reset = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rst_regrant_ready: got %b expected 0010", req_ready); end
    tick();
    set_req(1, 1'b0, 1'b1, 4'd0);
    n_checks++; if (grant_id !== 2'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_regrant: got grant %0d busy %0b expected 1 1", grant_id, busy); end
    tick(); tick();
    n_checks++; if (cnt_value !== 4'd2 || done_valid !== 1'b1 || done_id !== 2'd1) begin n_fail++; $display("FAIL rst_regrant_done: got cnt %0d done %0b id %0d expected 2 1 1", cnt_value, done_valid, done_id); end
    tick();
  endtask

  initial begin
    reset = 1'b1;
    clear = 1'b0;
    req_valid = '0;
    req_dir   = '0;
    req_len   = '0;
    test_reset();
    test_single_up();
    test_down_wrap();
    test_fairness();
    test_zero_len();
    test_clear_mid_run();
    test_reset_mid_run();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
